// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a byte stream big-endian into 512-bit blocks with FIPS 180-4 padding.
// Optional SHA256_PAD_STATUS_EN adds the msg_blocks per-message block counter output.
module sha256_padder #(
   parameter int LEN_W = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_data,
   input  logic         in_keep,
   input  logic         in_last,
   output logic         block_valid,
   input  logic         block_ready,
   output logic [511:0] block,
   output logic         block_first,
   output logic         block_last
`ifdef SHA256_PAD_STATUS_EN
   ,
   output logic [15:0]  msg_blocks
`endif
);

   typedef enum logic [1:0] {S_FILL, S_PAD, S_EMIT, S_LEN} state_t;

   state_t             state_q, state_d;
   logic [6:0]         idx_q, idx_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [511:0]       block_q, block_d;
   logic               first_pend_q, first_pend_d;
   logic               last_q, last_d;
   logic               len_pend_q, len_pend_d;
   logic               pad80_q, pad80_d;

   logic [63:0]        len64;
   logic [63:0]        lane_eq;
   logic [63:0]        lane_gt;
   logic               in_fire;
   logic               out_fire;

   assign len64    = 64'(len_q);
   assign in_fire  = in_valid && in_ready;
   assign out_fire = block_valid && block_ready;

   // Per-byte-lane decode of the write pointer: the lane being written and the lanes after it.
   genvar gi;
   generate
      for (gi = 0; gi < 64; gi++) begin : g_lane
         assign lane_eq[gi] = (idx_q == 7'(gi));
         assign lane_gt[gi] = (7'(gi) > idx_q);
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= S_FILL;
         idx_q        <= '0;
         len_q        <= '0;
         block_q      <= '0;
         first_pend_q <= 1'b1;
         last_q       <= 1'b0;
         len_pend_q   <= 1'b0;
         pad80_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         len_q        <= len_d;
         block_q      <= block_d;
         first_pend_q <= first_pend_d;
         last_q       <= last_d;
         len_pend_q   <= len_pend_d;
         pad80_q      <= pad80_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      len_d        = len_q;
      block_d      = block_q;
      first_pend_d = first_pend_q;
      last_d       = last_q;
      len_pend_d   = len_pend_q;
      pad80_d      = pad80_q;
      case (state_q)
         S_FILL: begin
            if (in_fire) begin
               if (in_keep) begin
                  for (int b = 0; b < 64; b++) begin
                     if (lane_eq[b]) block_d[511-8*b -: 8] = in_data;
                  end
                  idx_d = idx_q + 7'd1;
                  len_d = len_q + LEN_W'(8);
               end
               if (in_last) begin
                  state_d = S_PAD;
               end else if (in_keep && idx_q == 7'd63) begin
                  state_d    = S_EMIT;
                  last_d     = 1'b0;
                  len_pend_d = 1'b0;
               end
            end
         end
         S_PAD: begin
            // With idx==64 no lane matches, so the full data block passes through untouched.
            for (int b = 0; b < 64; b++) begin
               if (lane_eq[b])      block_d[511-8*b -: 8] = 8'h80;
               else if (lane_gt[b]) block_d[511-8*b -: 8] = 8'h00;
            end
            state_d = S_EMIT;
            if (idx_q <= 7'd55) begin
               block_d[63:0] = len64;
               last_d        = 1'b1;
               len_pend_d    = 1'b0;
               pad80_d       = 1'b0;
            end else begin
               last_d     = 1'b0;
               len_pend_d = 1'b1;
               pad80_d    = (idx_q == 7'd64);
            end
         end
         S_LEN: begin
            block_d    = {(pad80_q ? 8'h80 : 8'h00), 440'h0, len64};
            last_d     = 1'b1;
            len_pend_d = 1'b0;
            pad80_d    = 1'b0;
            state_d    = S_EMIT;
         end
         S_EMIT: begin
            if (out_fire) begin
               idx_d        = '0;
               first_pend_d = 1'b0;
               if (last_q) begin
                  len_d        = '0;
                  first_pend_d = 1'b1;
                  state_d      = S_FILL;
               end else if (len_pend_q) begin
                  state_d = S_LEN;
               end else begin
                  state_d = S_FILL;
               end
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   always_comb begin
      in_ready    = (state_q == S_FILL);
      block_valid = (state_q == S_EMIT);
      block_first = (state_q == S_EMIT) && first_pend_q;
      block_last  = (state_q == S_EMIT) && last_q;
      block       = block_q;
   end

`ifdef SHA256_PAD_STATUS_EN
   logic [15:0] msg_blocks_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         msg_blocks_q <= '0;
      end else if (out_fire) begin
         if (last_q)                     msg_blocks_q <= '0;
         else if (msg_blocks_q != 16'hFFFF) msg_blocks_q <= msg_blocks_q + 16'd1;
      end
   end

   assign msg_blocks = msg_blocks_q;
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// Scoreboard bench for sha256_padder: directed FIPS padding cases plus random messages vs a byte-level model.
module tb_sha256_padder;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [7:0]   in_data = 8'h00;
   logic         in_keep = 1'b0;
   logic         in_last = 1'b0;
   logic         block_valid;
   logic         block_ready = 1'b0;
   logic [511:0] block;
   logic         block_first;
   logic         block_last;
`ifdef SHA256_PAD_STATUS_EN
   logic [15:0]  msg_blocks;
`endif

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [511:0] blk;
      logic         first;
      logic         last;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_blocks = 0;
   bit   force_stall = 1'b0;

   sha256_padder #(.LEN_W(64)) dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_keep     (in_keep),
      .in_last     (in_last),
      .block_valid (block_valid),
      .block_ready (block_ready),
      .block       (block),
      .block_first (block_first),
      .block_last  (block_last)
`ifdef SHA256_PAD_STATUS_EN
      ,
      .msg_blocks  (msg_blocks)
`endif
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic push_exp(input logic [511:0] b, input logic f, input logic l);
      exp_q.push_back('{b, f, l});
   endtask

   // Reference: append 0x80, zero-fill to 56 mod 64, append 64-bit bit count, then slice into blocks.
   task automatic model_push(input bq_t msg);
      bq_t          p = msg;
      logic [63:0]  bitlen;
      logic [511:0] blk;
      int           nb;
      bitlen = 64'(msg.size()) * 64'd8;
      p.push_back(8'h80);
      while ((p.size() % 64) != 56) p.push_back(8'h00);
      for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
      nb = p.size() / 64;
      for (int b = 0; b < nb; b++) begin
         blk = '0;
         for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b + j];
         push_exp(blk, (b == 0), (b == nb - 1));
      end
   endtask

   task automatic send_beat(input logic [7:0] d, input logic k, input logic l, output bit ok);
      in_valid = 1'b1;
      in_data  = d;
      in_keep  = k;
      in_last  = l;
      ok       = 1'b0;
      for (int w = 0; w < 500; w++) begin
         @(negedge clock);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL beat_accept: in_ready stayed 0, required 1 within 500 cycles");
      end else begin
         @(posedge clock);
         #1;
      end
      in_valid = 1'b0;
      in_keep  = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_last_latency();
      @(negedge clock);
      chk("pad_cycle_valid", 512'(block_valid), 512'(0));
      @(negedge clock);
      chk("last_beat_latency_valid", 512'(block_valid), 512'(1));
   endtask

   task automatic send_msg(input bq_t msg, input bit trail_empty, input bit use_model);
      int n = msg.size();
      int cnt = 0;
      bit ok;
      bit lst;
      if (n == 0) trail_empty = 1'b1;
      if (use_model) model_push(msg);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 7) == 0) send_beat(8'($urandom), 1'b0, 1'b0, ok);
         repeat ($urandom_range(0, 1)) begin
            @(posedge clock);
            #1;
         end
         lst = (i == n - 1) && !trail_empty;
         send_beat(msg[i], 1'b1, lst, ok);
         cnt++;
         if (ok && lst) begin
            check_last_latency();
         end else if (ok && (cnt % 64) == 0) begin
            @(negedge clock);
            chk("full_block_latency_valid", 512'(block_valid), 512'(1));
         end
      end
      if (trail_empty) begin
         send_beat(8'($urandom), 1'b0, 1'b1, ok);
         if (ok) check_last_latency();
      end
      $display("message sent: %0d bytes, trailing empty beat %0d", n, trail_empty);
   endtask

   always @(posedge clock) begin
      #1;
      block_ready = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   logic [511:0] held_blk;
   logic         held_f, held_l;
   bit           held = 1'b0;
   exp_t         e;

   always @(negedge clock) begin
      if (!reset) begin
         held = 1'b0;
      end else begin
         if (held) begin
            chk("emit_hold_valid", 512'(block_valid), 512'(1));
            chk("emit_hold_block", block, held_blk);
            chk("emit_hold_first", 512'(block_first), 512'(held_f));
            chk("emit_hold_last", 512'(block_last), 512'(held_l));
         end
         if (block_valid) begin
            chk("in_ready_low_while_emit", 512'(in_ready), 512'(0));
            if (block_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_block: got block %0h, required no block", block);
               end else begin
                  e = exp_q.pop_front();
                  chk("block_data", block, e.blk);
                  chk("block_first", 512'(block_first), 512'(e.first));
                  chk("block_last", 512'(block_last), 512'(e.last));
                  n_blocks++;
                  $display("block %0d accepted: first=%0b last=%0b", n_blocks, block_first, block_last);
               end
               held = 1'b0;
            end else begin
               held     = 1'b1;
               held_blk = block;
               held_f   = block_first;
               held_l   = block_last;
            end
         end else begin
            held = 1'b0;
         end
      end
   end

   initial begin
      bq_t          m;
      logic [511:0] b64;
      bit           ok;
      int           n;

      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("reset_in_ready", 512'(in_ready), 512'(1));
      chk("reset_block_valid", 512'(block_valid), 512'(0));
      chk("reset_block_first", 512'(block_first), 512'(0));
      chk("reset_block_last", 512'(block_last), 512'(0));
      chk("reset_block", block, 512'(0));
      @(posedge clock);
      #1;
      reset = 1'b1;

      // "abc" with the hashing stage stalled for 10 cycles
      force_stall = 1'b1;
      @(posedge clock);
      #1;
      m = '{8'h61, 8'h62, 8'h63};
      push_exp({32'h61626380, 416'h0, 64'h18}, 1'b1, 1'b1);
      send_msg(m, 1'b0, 1'b0);
      repeat (10) begin
         @(negedge clock);
         chk("stall_in_ready", 512'(in_ready), 512'(0));
         chk("stall_block_valid", 512'(block_valid), 512'(1));
      end
      force_stall = 1'b0;

      m.delete();
      repeat (55) m.push_back(8'h41);
      push_exp({{55{8'h41}}, 8'h80, 64'h1B8}, 1'b1, 1'b1);
      send_msg(m, 1'b0, 1'b0);

      m.delete();
      repeat (56) m.push_back(8'h41);
      push_exp({{56{8'h41}}, 8'h80, 56'h0}, 1'b1, 1'b0);
      push_exp({448'h0, 64'h1C0}, 1'b0, 1'b1);
      send_msg(m, 1'b0, 1'b0);

      m.delete();
      b64 = '0;
      for (int j = 0; j < 64; j++) begin
         m.push_back(8'(j));
         b64[511-8*j -: 8] = 8'(j);
      end
      push_exp(b64, 1'b1, 1'b0);
      push_exp({8'h80, 440'h0, 64'h200}, 1'b0, 1'b1);
      send_msg(m, 1'b0, 1'b0);

      m.delete();
      push_exp({8'h80, 504'h0}, 1'b1, 1'b1);
      send_msg(m, 1'b1, 1'b0);

      // Reset in the middle of filling a block discards the partial message
      for (int w = 0; w < 2000 && (exp_q.size() != 0 || block_valid); w++) @(negedge clock);
      for (int i = 0; i < 10; i++) send_beat(8'($urandom), 1'b1, 1'b0, ok);
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk("midfill_reset_in_ready", 512'(in_ready), 512'(1));
      chk("midfill_reset_valid", 512'(block_valid), 512'(0));
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(negedge clock);
      chk("after_reset_valid", 512'(block_valid), 512'(0));
      m = '{8'h61, 8'h62, 8'h63};
      push_exp({32'h61626380, 416'h0, 64'h18}, 1'b1, 1'b1);
      send_msg(m, 1'b0, 1'b0);

      repeat (20) begin
         m.delete();
         n = $urandom_range(0, 150);
         for (int i = 0; i < n; i++) m.push_back(8'($urandom));
         send_msg(m, (n == 0) || ($urandom_range(0, 3) == 0), 1'b1);
      end

      for (int w = 0; w < 3000 && exp_q.size() != 0; w++) @(negedge clock);
      chk("scoreboard_drained", 512'(exp_q.size()), 512'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
